// File: rtl/seq_chk_pkg.sv
// Shared constants and types for the lagged-Fibonacci recurrence checker.
// Recurrence a(n) = a(n-1) + a(n-LAG), generator seed is SEED[0..LAG-1].
package seq_chk_pkg;

    localparam int LAG       = 5;
    localparam int DEFAULT_W = 64;

    localparam logic [2:0] SEED [0:LAG-1] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2};

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        CHECK = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_recurrence_checker_hist.sv
// LAG-deep term history for the recurrence checker; slot LAG-1 is newest.
// Reload clears every slot so the restart term 0 sits in the newest position.
module seq_hist_shift
    import seq_chk_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_shift,
    input  logic         i_reload,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_h0,
    output logic [W-1:0] o_h4
);

    logic [W-1:0] r_hist [0:LAG-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAG; i++) r_hist[i] <= '0;
        end else if (i_clear || i_reload) begin
            for (int i = 0; i < LAG; i++) r_hist[i] <= '0;
        end else if (i_shift) begin
            for (int i = 0; i < LAG - 1; i++) r_hist[i] <= r_hist[i + 1];
            r_hist[LAG-1] <= i_term;
        end
    end

    assign o_h0 = r_hist[0];
    assign o_h4 = r_hist[LAG-1];

endmodule

// File: rtl/seq_recurrence_checker.sv
// Checks an incoming lagged-Fibonacci stream against a(n) = a(n-1) + a(n-5).
// Optional macro SEQ_CHK_OVF_EN adds the ovf output and overflow tolerance.
module seq_recurrence_checker
    import seq_chk_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int CNT_W       = 32,
    parameter int ERR_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     in_term,
    output logic             chk_valid,
    output logic             chk_ok,
    output logic [W-1:0]     expected,
    output logic             primed,
    output logic             err_sticky,
    output logic [CNT_W-1:0] term_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fault
`ifdef SEQ_CHK_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int PC_W = $clog2(LAG + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_prime_cnt;
    logic             r_chk_valid;
    logic             r_chk_ok;
    logic [W-1:0]     r_expected;
    logic             r_primed;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_term_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    logic [W-1:0] w_h0;
    logic [W-1:0] w_h4;
    logic [W-1:0] w_exp;
    logic         w_tol;
    logic         w_prime_acc;
    logic         w_prime_done;
    logic         w_restart;
    logic         w_check;
    logic         w_match;
    logic         w_mismatch;
    logic         w_shift;

    seq_hist_shift #(.W(W)) u_hist (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (clear),
        .i_shift  (w_shift),
        .i_reload (w_restart),
        .i_term   (in_term),
        .o_h0     (w_h0),
        .o_h4     (w_h4)
    );

`ifdef SEQ_CHK_OVF_EN
    logic [W:0] w_sum;
    logic       r_ovf;
    assign w_sum = {1'b0, w_h4} + {1'b0, w_h0};
    assign w_exp = w_sum[W-1:0];
    assign w_tol = w_sum[W];
`else
    assign w_exp = w_h4 + w_h0;
    assign w_tol = 1'b0;
`endif

    // A zero after a nonzero newest term means the generator restarted,
    // unless the predicted sum wrapped, in which case 0 is a legitimate term.
    assign w_prime_acc  = in_valid && (r_state == PRIME);
    assign w_prime_done = w_prime_acc && (r_prime_cnt == PC_W'(LAG - 1));
    assign w_restart    = in_valid && (r_state == CHECK) && (in_term == '0)
                          && (w_h4 != '0) && !w_tol;
    assign w_check      = in_valid && (r_state == CHECK) && !w_restart;
    assign w_match      = (in_term == w_exp) || w_tol;
    assign w_mismatch   = w_check && !w_match;
    assign w_shift      = w_prime_acc || w_check;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= PRIME;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = PRIME;
        end else begin
            case (r_state)
                PRIME:   if (w_prime_done) w_state_nxt = CHECK;
                CHECK: begin
                    if (w_restart)                      w_state_nxt = PRIME;
                    else if (w_mismatch && STOP_ON_ERR) w_state_nxt = FAULT;
                end
                FAULT:   w_state_nxt = FAULT;
                default: w_state_nxt = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prime_cnt  <= '0;
            r_chk_valid  <= 1'b0;
            r_chk_ok     <= 1'b0;
            r_expected   <= '0;
            r_primed     <= 1'b0;
            r_err_sticky <= 1'b0;
            r_term_cnt   <= '0;
            r_err_cnt    <= '0;
        end else if (clear) begin
            r_prime_cnt  <= '0;
            r_chk_valid  <= 1'b0;
            r_chk_ok     <= 1'b0;
            r_expected   <= '0;
            r_primed     <= 1'b0;
            r_err_sticky <= 1'b0;
            r_term_cnt   <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_chk_valid <= w_check;
            if (w_check) begin
                r_chk_ok   <= w_match;
                r_expected <= w_exp;
            end
            if (w_shift || w_restart) r_term_cnt <= r_term_cnt + 1'b1;
            if (w_mismatch) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_restart) begin
                r_prime_cnt <= PC_W'(1);
                r_primed    <= 1'b0;
            end else if (w_prime_acc) begin
                r_prime_cnt <= r_prime_cnt + 1'b1;
                if (w_prime_done) r_primed <= 1'b1;
            end
        end
    end

`ifdef SEQ_CHK_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_ovf <= 1'b0;
        else if (clear)   r_ovf <= 1'b0;
        else if (w_check) r_ovf <= w_tol;
    end
    assign ovf = r_ovf;
`endif

    assign chk_valid  = r_chk_valid;
    assign chk_ok     = r_chk_ok;
    assign expected   = r_expected;
    assign primed     = r_primed;
    assign err_sticky = r_err_sticky;
    assign term_cnt   = r_term_cnt;
    assign err_cnt    = r_err_cnt;
    assign fault      = (r_state == FAULT);

endmodule

// File: tb/tb_seq_recurrence_checker.sv
// Bench for seq_recurrence_checker: three instances (default, STOP_ON_ERR=1,
// ERR_W=3) share one stimulus stream and are compared to a queue-based model.
module tb_seq_recurrence_checker;
    import seq_chk_pkg::*;

    localparam int W  = 64;
    localparam int NI = 3;
`ifdef SEQ_CHK_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic [W-1:0] in_term;

    logic [NI-1:0]         d_cv, d_ok, d_pr, d_st, d_ft, d_ovf;
    logic [NI-1:0][W-1:0]  d_exp;
    logic [NI-1:0][31:0]   d_tc;
    logic [NI-1:0][15:0]   d_ec;
    logic [2:0]            d_ec2;

    assign d_ec[2] = {13'd0, d_ec2};

    always #5 clk = ~clk;

    seq_recurrence_checker u_dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_term(in_term),
        .chk_valid(d_cv[0]), .chk_ok(d_ok[0]), .expected(d_exp[0]), .primed(d_pr[0]),
        .err_sticky(d_st[0]), .term_cnt(d_tc[0]), .err_cnt(d_ec[0]), .fault(d_ft[0])
`ifdef SEQ_CHK_OVF_EN
        , .ovf(d_ovf[0])
`endif
    );

    seq_recurrence_checker #(.STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_term(in_term),
        .chk_valid(d_cv[1]), .chk_ok(d_ok[1]), .expected(d_exp[1]), .primed(d_pr[1]),
        .err_sticky(d_st[1]), .term_cnt(d_tc[1]), .err_cnt(d_ec[1]), .fault(d_ft[1])
`ifdef SEQ_CHK_OVF_EN
        , .ovf(d_ovf[1])
`endif
    );

    seq_recurrence_checker #(.ERR_W(3)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_term(in_term),
        .chk_valid(d_cv[2]), .chk_ok(d_ok[2]), .expected(d_exp[2]), .primed(d_pr[2]),
        .err_sticky(d_st[2]), .term_cnt(d_tc[2]), .err_cnt(d_ec2), .fault(d_ft[2])
`ifdef SEQ_CHK_OVF_EN
        , .ovf(d_ovf[2])
`endif
    );

`ifndef SEQ_CHK_OVF_EN
    assign d_ovf = '0;
`endif

    // Reference model: the accepted-term history is a queue, newest at the back.
    logic [W-1:0] m_q [NI][$];
    int           m_mode [NI];      // 0 priming, 1 checking, 2 halted
    logic         m_cv [NI], m_ok [NI], m_pr [NI], m_st [NI], m_ovf [NI];
    logic [W-1:0] m_exp [NI];
    logic [31:0]  m_tc [NI];
    int           m_ec [NI];
    bit           m_stop [NI] = '{1'b0, 1'b1, 1'b0};
    int           m_emax [NI] = '{65535, 65535, 7};

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    logic [W-1:0] obs_exp [$];

    logic [W-1:0] g_h [0:LAG-1];
    int           g_idx = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        else n_pass++;
    endtask

    task automatic model_clear(input int i);
        m_q[i].delete();
        m_mode[i] = 0;
        m_cv[i] = 0; m_ok[i] = 0; m_pr[i] = 0; m_st[i] = 0; m_ovf[i] = 0;
        m_exp[i] = '0; m_tc[i] = '0; m_ec[i] = 0;
    endtask

    task automatic model_step(input logic clr, input logic v, input logic [W-1:0] t);
        logic [W:0] s;
        bit         of, rst_seq, ok;
        for (int i = 0; i < NI; i++) begin
            m_cv[i] = 1'b0;
            if (clr) begin
                model_clear(i);
            end else if (v && m_mode[i] == 0) begin
                m_q[i].push_back(t);
                m_tc[i] = m_tc[i] + 1;
                if (m_q[i].size() == LAG) begin m_mode[i] = 1; m_pr[i] = 1; end
            end else if (v && m_mode[i] == 1) begin
                s  = {1'b0, m_q[i][LAG-1]} + {1'b0, m_q[i][0]};
                of = OVF_EN && s[W];
                rst_seq = (t == '0) && (m_q[i][LAG-1] != '0) && !of;
                m_tc[i] = m_tc[i] + 1;
                if (rst_seq) begin
                    m_q[i].delete();
                    m_q[i].push_back('0);
                    m_mode[i] = 0;
                    m_pr[i] = 0;
                end else begin
                    ok = (t == s[W-1:0]) || of;
                    m_cv[i] = 1; m_ok[i] = ok; m_exp[i] = s[W-1:0]; m_ovf[i] = s[W];
                    if (!ok) begin
                        m_st[i] = 1;
                        if (m_ec[i] < m_emax[i]) m_ec[i]++;
                        if (m_stop[i]) m_mode[i] = 2;
                    end
                    m_q[i].push_back(t);
                    void'(m_q[i].pop_front());
                end
            end
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < NI; i++) begin
            chk_eq($sformatf("u%0d.chk_valid", i), 64'(d_cv[i]), 64'(m_cv[i]));
            chk_eq($sformatf("u%0d.chk_ok", i), 64'(d_ok[i]), 64'(m_ok[i]));
            chk_eq($sformatf("u%0d.expected", i), d_exp[i], m_exp[i]);
            chk_eq($sformatf("u%0d.primed", i), 64'(d_pr[i]), 64'(m_pr[i]));
            chk_eq($sformatf("u%0d.err_sticky", i), 64'(d_st[i]), 64'(m_st[i]));
            chk_eq($sformatf("u%0d.term_cnt", i), 64'(d_tc[i]), 64'(m_tc[i]));
            chk_eq($sformatf("u%0d.err_cnt", i), 64'(d_ec[i]), 64'(m_ec[i]));
            chk_eq($sformatf("u%0d.fault", i), 64'(d_ft[i]), 64'(m_mode[i] == 2));
            if (OVF_EN) chk_eq($sformatf("u%0d.ovf", i), 64'(d_ovf[i]), 64'(m_ovf[i]));
        end
    endtask

    task automatic step(input logic clr, input logic v, input logic [W-1:0] t);
        clear = clr; in_valid = v; in_term = t;
        @(posedge clk);
        model_step(clr, v, t);
        #1;
        cmp_all();
        if (d_cv[0]) begin n_pulse++; obs_exp.push_back(d_exp[0]); end
        clear = 1'b0; in_valid = 1'b0;
    endtask

    task automatic gen_term(output logic [W-1:0] t);
        if (g_idx < LAG) begin t = 64'(SEED[g_idx]); g_idx++; end
        else t = g_h[LAG-1] + g_h[0];
        for (int k = 0; k < LAG - 1; k++) g_h[k] = g_h[k+1];
        g_h[LAG-1] = t;
    endtask

    logic [W-1:0] clean_s [12] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12};
    logic [W-1:0] want_e  [7]  = '{2, 3, 4, 5, 7, 9, 12};
    logic [W-1:0] rs_s    [7]  = '{0, 1, 1, 1, 2, 2, 3};
    logic [W-1:0] t;
    int           r;

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_term = '0;
        for (int i = 0; i < NI; i++) model_clear(i);
        #7;
        cmp_all();
        reset = 1'b0;

        // clean seed stream
        n_pulse = 0; obs_exp.delete();
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, clean_s[k]);
            if (k == 3) chk_eq("clean.primed_early", 64'(d_pr[0]), 64'd0);
            if (k == 4) chk_eq("clean.primed_5th", 64'(d_pr[0]), 64'd1);
        end
        chk_eq("clean.pulses", 64'(n_pulse), 64'd7);
        if (obs_exp.size() == 7)
            for (int k = 0; k < 7; k++) chk_eq($sformatf("clean.exp%0d", k), obs_exp[k], want_e[k]);
        chk_eq("clean.term_cnt", 64'(d_tc[0]), 64'd12);
        chk_eq("clean.err_cnt", 64'(d_ec[0]), 64'd0);

        // corrupt 8th term, clear has priority over the valid term in the same cycle
        step(1'b1, 1'b1, 64'd5);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, (k == 7) ? 64'd6 : clean_s[k]);
            if (k == 7) begin
                chk_eq("bad.chk_ok", 64'(d_ok[0]), 64'd0);
                chk_eq("bad.expected", d_exp[0], 64'd4);
                chk_eq("bad.stop_fault", 64'(d_ft[1]), 64'd1);
            end
            if (k == 8) chk_eq("bad.next_expected", d_exp[0], 64'd7);
        end
        chk_eq("bad.err_cnt", 64'(d_ec[0]), 64'd2);
        chk_eq("bad.sticky", 64'(d_st[0]), 64'd1);
        chk_eq("bad.stop_term_cnt", 64'(d_tc[1]), 64'd8);

        // generator restart on a primed stream
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, rs_s[k]);
            if (k == 0) chk_eq("rs.primed_drop", 64'(d_pr[0]), 64'd0);
            if (k == 4) chk_eq("rs.primed_back", 64'(d_pr[0]), 64'd1);
        end
        chk_eq("rs.err_cnt", 64'(d_ec[0]), 64'd2);

        step(1'b1, 1'b0, '0);
        chk_eq("clr.fault", 64'(d_ft[1]), 64'd0);
        chk_eq("clr.term_cnt", 64'(d_tc[1]), 64'd0);

        // asynchronous reset between edges
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, clean_s[k]);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) model_clear(i);
        cmp_all();
        chk_eq("arst.term_cnt", 64'(d_tc[0]), 64'd0);
        #1 reset = 1'b0;
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, clean_s[k]);
        chk_eq("arst.err_cnt", 64'(d_ec[0]), 64'd0);

        // ten mismatching terms: u_sat saturates at 7
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, clean_s[k]);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 64'h00A5_0000 + 64'(3 * k));
        chk_eq("sat.err_cnt", 64'(d_ec[0]), 64'd10);
        chk_eq("sat.err_cnt_small", 64'(d_ec[2]), 64'd7);

`ifdef SEQ_CHK_OVF_EN
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 64'd1);
        step(1'b0, 1'b1, 64'd5);
        step(1'b0, 1'b1, 64'd6);
        step(1'b0, 1'b1, 64'd7);
        step(1'b0, 1'b1, '1);
        step(1'b0, 1'b1, '0);
        chk_eq("ovf.ovf", 64'(d_ovf[0]), 64'd1);
        chk_eq("ovf.chk_valid", 64'(d_cv[0]), 64'd1);
        chk_eq("ovf.chk_ok", 64'(d_ok[0]), 64'd1);
        chk_eq("ovf.primed", 64'(d_pr[0]), 64'd1);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 64'd2);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 64'd0);
        step(1'b0, 1'b1, '1);
        step(1'b0, 1'b1, 64'd7);
        chk_eq("ovf.tol_ok", 64'(d_ok[0]), 64'd1);
        chk_eq("ovf.tol_err", 64'(d_ec[0]), 64'd0);
`endif

        // randomized stream: gaps, corruptions, restarts, clears
        step(1'b1, 1'b0, '0);
        g_idx = 0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 199));
            if (r < 3) begin
                g_idx = 0;
                step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            end else if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'b0, {$urandom, $urandom});
            end else begin
                if (r < 6) g_idx = 0;
                gen_term(t);
                if (r >= 6 && r < 14) t = t ^ {$urandom, $urandom | 32'd1};
                step(1'b0, 1'b1, t);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
